adc_scan: RTL and testbench
===========================

ADC_SCAN -- requirements
Module: adc_scan

Interface
REQ-001 Parameter NUM_CH, default 4: number of channels scanned per sweep, legal range 1..8.
REQ-002 Parameter CH_MAP, default 24'h000_000 + {3'd5,3'd4,3'd3,3'd0}: 3-bit A2D channel number for each scan slot, slot i at bits [3i+2:3i], NUM_CH*3 bits wide.
REQ-003 Parameter LOW_THRES, default 12'h800: a channel whose result is below this value flags low.
REQ-004 clk  input  1  system clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 nxt  input  1  one-cycle pulse that starts a sweep.
REQ-007 wrt  output  1  one-cycle request to the SPI master to start a transaction.
REQ-008 cmd  output  16  SPI command word, valid while wrt is high.
REQ-009 done  input  1  one-cycle pulse from the SPI master when a transaction ends.
REQ-010 rd_data  input  16  SPI read word, valid in the cycle done is high.
REQ-011 result  output  NUM_CH*12  registered 12-bit result per slot, slot i at [12i+11:12i].
REQ-012 low_flag  output  NUM_CH  registered per slot, high when result < LOW_THRES.
REQ-013 busy  output  1  high from the cycle after an accepted nxt until the sweep ends.
REQ-014 scan_done  output  1  one-cycle pulse when a sweep has fully updated.

Function
REQ-015 The state machine SHALL have the states IDLE, CMD, WAIT1, GAP, READ, WAIT2.
REQ-016 IDLE + nxt: the slot index SHALL be cleared to 0 and the next state SHALL be CMD; nxt in any other state SHALL be ignored.
REQ-017 CMD: wrt=1, cmd={2'b00,CH_MAP[slot],11'h000}; next state WAIT1.
REQ-018 WAIT1: hold until done; then GAP, with exactly one idle cycle (wrt=0).
REQ-019 READ: wrt=1, cmd identical to the CMD word; next state WAIT2.
REQ-020 WAIT2 + done: result[slot] and low_flag[slot] SHALL update on that same clock edge from rd_data[11:0]; rd_data[15:12] SHALL be ignored.
REQ-021 After the WAIT2 capture: if slot==NUM_CH-1, go to IDLE and assert scan_done in the following cycle; otherwise increment slot and go to CMD.
REQ-022 The slot index SHALL be $clog2(NUM_CH) bits wide, minimum 1, and SHALL never exceed NUM_CH-1.
REQ-023 The low comparison SHALL be unsigned and strict: 12'h7FF flags, 12'h800 does not.
REQ-024 done seen outside WAIT1/WAIT2 SHALL be ignored.
REQ-025 nxt in the same cycle as scan_done SHALL start a new sweep.
REQ-026 wrt SHALL be high for exactly one cycle per transaction, giving 2*NUM_CH transactions per sweep.
REQ-027 Results from untouched slots SHALL keep their values during a sweep.

Reset
REQ-028 On a clock edge with rst=1: state=IDLE, slot=0, wrt=0, cmd=0, busy=0, scan_done=0, all results=0, all low_flag=0 (cleared despite 0<LOW_THRES).
REQ-029 A reset mid-sweep SHALL abandon the sweep without scan_done, and a done arriving afterwards SHALL be ignored.

Configuration
REQ-030 Macro ADC_SCAN_AVG_EN defined: the stored result SHALL be (old+new+1)>>1, computed at 13 bits, except that the first capture after reset stores new directly; low_flag SHALL use the stored value.
REQ-031 Macro ADC_SCAN_AVG_EN undefined: the stored result SHALL be rd_data[11:0] directly, with no averaging logic.

Verification
REQ-032 NUM_CH=4, default map, nxt pulse with a responder returning 12'h123,12'h456,12'h789,12'hABC: cmd channels 0,3,4,5 each issued twice, results match, scan_done once, busy spans the sweep.
REQ-033 Threshold boundary: return 12'h7FF on slot 0 and 12'h800 on slot 1: low_flag[0]=1, low_flag[1]=0.
REQ-034 nxt pulsed during WAIT1 and an extra done in GAP: no extra wrt, transaction count stays 8.
REQ-035 rst asserted in WAIT2 of slot 2, then done: results=0, state IDLE, no scan_done; a new nxt runs a full sweep.
REQ-036 ADC_SCAN_AVG_EN defined, two sweeps returning 12'h100 then 12'h301: second-sweep result 12'h201; without the macro the result is 12'h301.
REQ-037 NUM_CH=1 and NUM_CH=8: exactly 2 and 16 transactions, slot index never out of range.

Source files
------------

// File: rtl/adc_scan.sv
// adc_scan: sweeps NUM_CH A2D channels through an SPI master, two transactions per slot.
// Optional macro ADC_SCAN_AVG_EN stores a rounded running average instead of the raw sample.
module adc_scan #(
  parameter int                  NUM_CH    = 4,
  parameter logic [NUM_CH*3-1:0] CH_MAP    = {3'd5, 3'd4, 3'd3, 3'd0},
  parameter logic [11:0]         LOW_THRES = 12'h800
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   nxt,
  output logic                   wrt,
  output logic [15:0]            cmd,
  input  logic                   done,
  input  logic [15:0]            rd_data,
  output logic [NUM_CH*12-1:0]   result,
  output logic [NUM_CH-1:0]      low_flag,
  output logic                   busy,
  output logic                   scan_done
);

  localparam int SW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, CMD, WAIT1, GAP, READ, WAIT2} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] slot;
  logic [2:0]    chan;
  logic          capture;
  logic [11:0]   sample, stored;
  logic          unused_hi;

  assign sample    = rd_data[11:0];
  assign unused_hi = ^rd_data[15:12];
  assign busy      = (state != IDLE);

  always_comb begin
    chan = 3'd0;
    for (int i = 0; i < NUM_CH; i++)
      if (slot == SW'(i)) chan = CH_MAP[3*i +: 3];
  end

  always_comb begin
    state_nxt = state;
    wrt       = 1'b0;
    cmd       = 16'h0000;
    capture   = 1'b0;
    case (state)
      IDLE:  if (nxt) state_nxt = CMD;
      CMD: begin
        wrt       = 1'b1;
        cmd       = {2'b00, chan, 11'h000};
        state_nxt = WAIT1;
      end
      WAIT1: if (done) state_nxt = GAP;
      GAP:   state_nxt = READ;
      READ: begin
        wrt       = 1'b1;
        cmd       = {2'b00, chan, 11'h000};
        state_nxt = WAIT2;
      end
      WAIT2: begin
        if (done) begin
          capture   = 1'b1;
          state_nxt = (slot == LAST) ? IDLE : CMD;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      scan_done <= capture && (slot == LAST);
      if (state == IDLE && nxt)
        slot <= '0;
      else if (capture && slot != LAST)
        slot <= slot + 1'b1;
    end
  end

`ifdef ADC_SCAN_AVG_EN
  // Each slot stores its first post-reset sample raw, then averages with rounding.
  logic [NUM_CH-1:0] seen;
  logic [11:0]       old_val;
  logic              seen_cur;
  logic [12:0]       sum;

  always_comb begin
    old_val  = 12'h000;
    seen_cur = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (slot == SW'(i)) begin
        old_val  = result[12*i +: 12];
        seen_cur = seen[i];
      end
    sum    = {1'b0, old_val} + {1'b0, sample} + 13'd1;
    stored = seen_cur ? sum[12:1] : sample;
  end

  always_ff @(posedge clk) begin
    if (rst)
      seen <= '0;
    else if (capture)
      for (int i = 0; i < NUM_CH; i++)
        if (slot == SW'(i)) seen[i] <= 1'b1;
  end
`else
  assign stored = sample;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result   <= '0;
      low_flag <= '0;
    end else if (capture) begin
      for (int i = 0; i < NUM_CH; i++)
        if (slot == SW'(i)) begin
          result[12*i +: 12] <= stored;
          low_flag[i]        <= (stored < LOW_THRES);
        end
    end
  end

endmodule

// File: tb/tb_adc_scan.sv
// tb_adc_scan: scoreboard bench for adc_scan with 4, 1 and 8 channel instances.
module tb_adc_scan;

  localparam int NUM_CH = 4;
  localparam logic [11:0] THRES = 12'h800;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 nxt = 1'b0;
  logic                 done = 1'b0;
  logic [15:0]          rd_data = 16'h0000;
  logic                 wrt, busy, scan_done;
  logic [15:0]          cmd;
  logic [NUM_CH*12-1:0] result;
  logic [NUM_CH-1:0]    low_flag;

  always #5 clk = ~clk;

  adc_scan dut (
    .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .cmd(cmd), .done(done),
    .rd_data(rd_data), .result(result), .low_flag(low_flag), .busy(busy),
    .scan_done(scan_done)
  );

  logic        nxt1 = 1'b0, done1 = 1'b0, wrt1, busy1, scan1;
  logic [15:0] rd1 = 16'h0000, cmd1;
  logic [11:0] result1;
  logic [0:0]  low1;

  adc_scan #(.NUM_CH(1), .CH_MAP(3'd6)) dut1 (
    .clk(clk), .rst(rst), .nxt(nxt1), .wrt(wrt1), .cmd(cmd1), .done(done1),
    .rd_data(rd1), .result(result1), .low_flag(low1), .busy(busy1),
    .scan_done(scan1)
  );

  logic        nxt8 = 1'b0, done8 = 1'b0, wrt8, busy8, scan8;
  logic [15:0] rd8 = 16'h0000, cmd8;
  logic [95:0] result8;
  logic [7:0]  low8;

  adc_scan #(.NUM_CH(8), .CH_MAP({3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0})) dut8 (
    .clk(clk), .rst(rst), .nxt(nxt8), .wrt(wrt8), .cmd(cmd8), .done(done8),
    .rd_data(rd8), .result(result8), .low_flag(low8), .busy(busy8),
    .scan_done(scan8)
  );

  int          total = 0;
  int          bad = 0;
  int          wrt_cnt = 0;
  int          done_cnt = 0;
  logic        prev_wrt = 1'b0;
  logic [15:0] exp_cmd[$];
  logic [2:0]  ch_map[NUM_CH] = '{3'd0, 3'd3, 3'd4, 3'd5};
  logic [11:0] model[NUM_CH];
  logic [11:0] resp[NUM_CH];
`ifdef ADC_SCAN_AVG_EN
  bit          seen[NUM_CH];
`endif

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic finishRun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic waitWrt(input string tag);
    int n = 0;
    while (!wrt && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!wrt) begin
      checkOutput(tag, 64'(wrt), 64'd1);
      finishRun();
    end
  endtask

  function automatic logic [11:0] slotRes(input int s);
    return result[12*s +: 12];
  endfunction

  // Scoreboard: every wrt pops the next expected command word.
  always begin
    @(posedge clk);
    #2;
    if (wrt) begin
      wrt_cnt++;
      checkOutput("wrt_width", 64'(prev_wrt), 64'd0);
      if (exp_cmd.size() == 0)
        checkOutput("cmd_unexpected", 64'(cmd) | 64'h10000, 64'h0);
      else
        checkOutput("cmd", 64'(cmd), 64'(exp_cmd.pop_front()));
    end
    if (scan_done) done_cnt++;
    prev_wrt = wrt;
  end

  // Auto-responders for the 1- and 8-channel instances: done three cycles after wrt.
  int         pend1 = 0, w1_cnt = 0, s1_cnt = 0;
  logic [2:0] ch1 = 3'd0;
  always @(negedge clk) begin
    done1 = 1'b0;
    if (scan1) s1_cnt++;
    if (wrt1) begin
      w1_cnt++;
      ch1   = cmd1[13:11];
      pend1 = 3;
    end else if (pend1 > 0) begin
      pend1--;
      if (pend1 == 0) begin
        done1 = 1'b1;
        rd1   = {4'h0, 8'hA0, 1'b0, ch1};
      end
    end
  end

  int         pend8 = 0, w8_cnt = 0, s8_cnt = 0;
  logic [2:0] ch8 = 3'd0;
  logic [7:0] mask8 = 8'h00;
  always @(negedge clk) begin
    done8 = 1'b0;
    if (scan8) s8_cnt++;
    if (wrt8) begin
      w8_cnt++;
      ch8        = cmd8[13:11];
      mask8[ch8] = 1'b1;
      pend8      = 3;
    end else if (pend8 > 0) begin
      pend8--;
      if (pend8 == 0) begin
        done8 = 1'b1;
        rd8   = {4'h0, 8'hA0, 1'b0, ch8};
      end
    end
  end

  // One sweep; abort_slot >= 0 resets in WAIT2 of that slot, inject adds nxt/done noise.
  task automatic applyStimulus(input int abort_slot, input bit inject);
    int w0 = wrt_cnt;
    int d0 = done_cnt;
    bit aborted = 0;
    for (int s = 0; s < NUM_CH; s++) begin
      exp_cmd.push_back({2'b00, ch_map[s], 11'h000});
      exp_cmd.push_back({2'b00, ch_map[s], 11'h000});
    end
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    checkOutput("busy_start", 64'(busy), 64'd1);
    for (int s = 0; s < NUM_CH; s++) begin
      waitWrt("wrt_cmd_timeout");
      @(negedge clk);
      if (inject && s == 0) nxt = 1'b1;
      @(negedge clk);
      nxt     = 1'b0;
      done    = 1'b1;
      rd_data = 16'hFFFF;
      @(negedge clk);
      done = 1'b0;
      if (inject && s == 0) begin
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
      end
      waitWrt("wrt_read_timeout");
      @(negedge clk);
      if (s == abort_slot) begin
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1;
      end
      rd_data = {4'(s + 9), resp[s]};
      done    = 1'b1;
      if (!aborted) begin
`ifdef ADC_SCAN_AVG_EN
        if (seen[s]) model[s] = 12'((int'(model[s]) + int'(resp[s]) + 1) / 2);
        else model[s] = resp[s];
        seen[s] = 1;
`else
        model[s] = resp[s];
`endif
      end
      @(negedge clk);
      done = 1'b0;
      if (aborted) break;
      if (s < NUM_CH - 1) checkOutput("busy_mid", 64'(busy), 64'd1);
    end
    if (aborted) begin
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_result", 64'(result), 64'd0);
      checkOutput("abort_low", 64'(low_flag), 64'd0);
      checkOutput("abort_left_cmds", 64'(exp_cmd.size()), 64'(2 * (NUM_CH - 1 - abort_slot)));
      exp_cmd.delete();
      repeat (5) @(negedge clk);
      checkOutput("abort_no_scan_done", 64'(done_cnt - d0), 64'd0);
      checkOutput("abort_wrt_count", 64'(wrt_cnt - w0), 64'(2 * (abort_slot + 1)));
      for (int s = 0; s < NUM_CH; s++) begin
        model[s] = 12'h000;
`ifdef ADC_SCAN_AVG_EN
        seen[s] = 0;
`endif
      end
    end else begin
      checkOutput("scan_done", 64'(scan_done), 64'd1);
      checkOutput("busy_end", 64'(busy), 64'd0);
      checkOutput("scan_done_count", 64'(done_cnt - d0), 64'd1);
      checkOutput("txn_count", 64'(wrt_cnt - w0), 64'(2 * NUM_CH));
      for (int s = 0; s < NUM_CH; s++) begin
        checkOutput($sformatf("result%0d", s), 64'(slotRes(s)), 64'(model[s]));
        checkOutput($sformatf("low%0d", s), 64'(low_flag[s]), 64'(model[s] < THRES));
      end
    end
  endtask

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    finishRun();
  end

  initial begin
    int n;
    for (int s = 0; s < NUM_CH; s++) model[s] = 12'h000;
`ifdef ADC_SCAN_AVG_EN
    for (int s = 0; s < NUM_CH; s++) seen[s] = 0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_wrt", 64'(wrt), 64'd0);
    checkOutput("rst_cmd", 64'(cmd), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_scan_done", 64'(scan_done), 64'd0);
    checkOutput("rst_result", 64'(result), 64'd0);
    checkOutput("rst_low", 64'(low_flag), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    resp = '{12'h123, 12'h456, 12'h789, 12'hABC};
    applyStimulus(-1, 0);
    repeat (3) @(negedge clk);

    resp = '{12'h7FF, 12'h800, 12'h100, 12'hFFF};
    applyStimulus(-1, 1);
    repeat (2) @(negedge clk);

    resp = '{12'h321, 12'h654, 12'h987, 12'hCBA};
    applyStimulus(2, 0);

    resp = '{12'h100, 12'h100, 12'h100, 12'h100};
    applyStimulus(-1, 0);
    resp = '{12'h301, 12'h301, 12'h301, 12'h301};
    applyStimulus(-1, 0);
`ifdef ADC_SCAN_AVG_EN
    checkOutput("avg_result", 64'(slotRes(0)), 64'h201);
`else
    checkOutput("raw_result", 64'(slotRes(0)), 64'h301);
`endif
    repeat (2) @(negedge clk);

    nxt1 = 1'b1;
    nxt8 = 1'b1;
    @(negedge clk);
    nxt1 = 1'b0;
    nxt8 = 1'b0;
    n = 0;
    while ((s1_cnt == 0 || s8_cnt == 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    checkOutput("ch1_txn", 64'(w1_cnt), 64'd2);
    checkOutput("ch1_scans", 64'(s1_cnt), 64'd1);
    checkOutput("ch1_result", 64'(result1), 64'hA06);
    checkOutput("ch1_busy", 64'(busy1), 64'd0);
    checkOutput("ch8_txn", 64'(w8_cnt), 64'd16);
    checkOutput("ch8_scans", 64'(s8_cnt), 64'd1);
    checkOutput("ch8_chmask", 64'(mask8), 64'hFF);
    checkOutput("ch8_result0", 64'(result8[11:0]), 64'hA00);
    checkOutput("ch8_result7", 64'(result8[95:84]), 64'hA07);
    checkOutput("ch8_low", 64'(low8), 64'd0);
    checkOutput("ch8_busy", 64'(busy8), 64'd0);
    finishRun();
  end

endmodule
